// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-back path.
//   XLEN     : register data width
//   NREG     : number of architectural registers
//   RF_AW    : register address width
//   wb_req_t : one pending write (destination register + data)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RF_AW = 5;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order buffer for ALU write-back requests that lost arbitration.
//   clk   : clock
//   reset : asynchronous active-low reset (empties the buffer)
//   push  : write din at the tail (ignored while full)
//   din   : request to store
//   pop   : drop the head entry (ignored while empty)
//   head  : oldest stored request (valid only while !empty)
//   full  : DEPTH entries stored
//   empty : no entries stored
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Arbitrates ALU and LSU results onto the register file's single write port
// and tracks which registers still have a write in flight.
//   clk, reset            : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data : ALU result handshake (ready = buffer not full)
//   lsu_valid/ready/rd/data : load result handshake (ready drops only on a
//                             forced buffer turn)
//   issue_valid/rd        : instruction with a destination register issuing
//   issue_stall           : issue_rd already has a write pending (comb.)
//   pending_mask          : bit r set while a write to x[r] is in flight
//   write_enable/addr/data: registered register-file write port
// Priority per cycle: forced buffer turn > LSU > buffer head > ALU bypass.
// -----------------------------------------------------------------------------
module regfile_writeback
  import regfile_pkg::RF_AW, regfile_pkg::wb_req_t;
#(
  parameter int XLEN       = regfile_pkg::XLEN,  // must match regfile_pkg
  parameter int NREG       = regfile_pkg::NREG,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [RF_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [RF_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             issue_valid,
  input  logic [RF_AW-1:0] issue_rd,
  output logic             issue_stall,
  output logic [NREG-1:0]  pending_mask,
  output logic             write_enable,
  output logic [RF_AW-1:0] write_addr,
  output logic [XLEN-1:0]  write_data
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   starve_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  wb_req_t         fifo_head;
  wb_req_t         alu_req;
  wb_req_t         win_req;
  logic            win_valid;
  logic            win_write;
  logic            force_turn;
  logic            lsu_win;
  logic            head_win;
  logic            bypass_win;
  logic            alu_accept;
  logic            fifo_push;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign force_turn = !fifo_empty && (starve_cnt == SW'(STARVE_MAX));
  assign lsu_win    = !force_turn && lsu_valid;
  assign head_win   = force_turn || (!lsu_valid && !fifo_empty);
  // Bypass only with an empty buffer keeps ALU results in acceptance order.
  assign bypass_win = !lsu_valid && fifo_empty && alu_valid;

  // Both readies are forced low while reset is held.
  assign alu_ready  = reset && !fifo_full;
  assign lsu_ready  = reset && !force_turn;

  assign alu_accept = alu_valid && !fifo_full;
  assign fifo_push  = alu_accept && !bypass_win;
  assign alu_req    = '{rd: alu_rd, data: alu_data};

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    win_req = '0;
    if (head_win)        win_req = fifo_head;
    else if (lsu_win)    win_req = '{rd: lsu_rd, data: lsu_data};
    else if (bypass_win) win_req = alu_req;
  end

  assign win_valid = head_win || lsu_win || bypass_win;
  // A result for x0 still uses its slot but never strobes the file.
  assign win_write = win_valid && (win_req.rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (alu_req),
    .pop   (head_win),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Starvation counter: counts LSU wins taken over a waiting buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || head_win) begin
      starve_cnt <= '0;
    end else if (lsu_win) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: winner of cycle N writes during cycle N+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= win_write;
      if (win_write) begin
        write_addr <= win_req.rd;
        write_data <= win_req.data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. The clear follows the write strobe, so a bit drops on the same
  // edge the register file captures the data.
  // ---------------------------------------------------------------------------
  assign issue_stall = issue_valid && (issue_rd != '0) && pending_mask[issue_rd];

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (issue_valid && !issue_stall && (issue_rd != '0)) pend_set[issue_rd] = 1'b1;
    if (write_enable) pend_clr[write_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= (pending_mask & ~pend_clr) | pend_set;
    end
  end

endmodule
